vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Produces the raster scan that all sprite and overlay renderers consume: hcount, vcount, blank, hsync, vsync.
- Those renderers include the coin, character and background blocks.
- It is the producer end of the pixel-position interface; every renderer samples its outputs on the same clk.
- It divides the system clock into a pixel-rate enable and exports frame/line strobes for game-logic updates.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel (>=1)
SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 when active

Ports:
clk  input  1  system clock; only clock in the block
reset  input  1  asynchronous, active-high; clears all state immediately
en  input  1  scan enable; low freezes the raster
hcount  output  11  current pixel column, 0..H_TOTAL-1
vcount  output  11  current line, 0..V_TOTAL-1
blank  output  1  high outside the active area
hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
pix_en  output  1  one-clk pulse per pixel period
line_start  output  1  one-clk pulse when hcount wraps to 0
frame_start  output  1  one-clk pulse when (hcount,vcount) wraps to (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). All compares use 11-bit unsigned values.
- Reset is asynchronous and active-high. On reset:
  - hcount=0, vcount=0, blank=0.
  - hsync and vsync at their inactive level (1 when SYNC_ACTIVE_LOW=1).
  - pix_en=0, line_start=0, frame_start=0; divider count=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while en=1; pix_en is registered high on the clk where div_cnt wraps to 0.
  - CLK_DIV=1: pix_en is high every clk while en=1.
  - First pix_en after reset release with en=1 occurs CLK_DIV clks later.
- Counters advance on each clk where pix_en is high:
  - hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- All outputs are registered and mutually aligned: blank/hsync/vsync describe the hcount/vcount presented in the same cycle. Implementation computes them from next-state counter values; there is no extra pipeline skew.
- blank = (hcount >= H_ACTIVE) || (vcount >= V_ACTIVE).
- hsync active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
- vsync active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491. vsync changes only on hcount wrap.
- line_start / frame_start:
  - Asserted for exactly one clk, coincident with the cycle hcount first shows 0 (resp. hcount=vcount=0) after a wrap.
  - Never asserted by reset itself.
- en:
  - en=0 holds div_cnt, counters and sync levels; forces pix_en, line_start and frame_start to 0.
  - Re-asserting en resumes from the held position with no skipped or repeated pixel.
- Reset mid-frame returns to (0,0) asynchronously; no frame_start is issued for that restart.
- Illegal parameters (CLK_DIV=0, any porch or sync width 0, H_TOTAL or V_TOTAL > 2047) are rejected by an elaboration-time check.

Decomposition:
- Shared package vga_pkg holds:
  - 640x480@60 timing constants (the defaults above).
  - COORD_W=11.
  - Derived H_TOTAL/V_TOTAL functions, reused by the coin and character renderers for their bounds.
- One sub-module, pix_clk_en: the CLK_DIV enable divider with en hold. The counters and sync decode stay in the top.

Test Plan:
- Reset release, en=1, CLK_DIV=2 -> first pix_en at clk 2; hcount 0->1 on that edge; blank=0, hsync=1, vsync=1.
- Run one full line -> hcount reaches 799 then 0; line_start one clk at the wrap; blank rises at hcount=640; hsync low exactly for hcount 656..751 (96 pixels, 192 clks).
- Run one full frame -> frame_start pulses once, 840000 clks after the previous frame_start; vsync low for lines 490..491 only (1600 pixels); blank high for all of vcount 480..524.
- en=0 held 37 clks at hcount=123 -> all counters and syncs frozen, pix_en=0; resume gives hcount=124 after the next CLK_DIV clks.
- Assert reset asynchronously (between edges) at hcount=700, vcount=300 -> outputs return to reset values before the next edge; no frame_start pulse.
- CLK_DIV=1, SYNC_ACTIVE_LOW=0 -> pix_en constantly high; hsync high for 656..751; frame period 420000 clks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared raster timing constants and helpers for the VGA pipeline.
// Defaults describe 640x480 at 60 Hz; renderers reuse the total helpers for their bounds.
package vga_pkg;

    localparam int COORD_W = 11;

    localparam int H_ACTIVE_DEF        = 640;
    localparam int H_FP_DEF            = 16;
    localparam int H_SYNC_DEF          = 96;
    localparam int H_BP_DEF            = 48;
    localparam int V_ACTIVE_DEF        = 480;
    localparam int V_FP_DEF            = 10;
    localparam int V_SYNC_DEF          = 2;
    localparam int V_BP_DEF            = 33;
    localparam int CLK_DIV_DEF         = 2;
    localparam int SYNC_ACTIVE_LOW_DEF = 1;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_pix_clk_en.sv
// Divides the system clock into a pixel-rate enable; en low freezes the divider.
// tick_o is the combinational "advance now" term, pix_en_o is its registered copy.
module pix_clk_en #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tick_o,
    output logic pix_en_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pix_en_q, pix_en_d;
    logic             tick;

    always_comb begin
        tick      = en_i && (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q;
        pix_en_d  = tick;
        if (en_i) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            pix_en_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pix_en_q  <= pix_en_d;
        end
    end

    assign tick_o   = tick;
    assign pix_en_o = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan producer: pixel/line counters plus blank and sync decode.
// Every output is registered from next-state values so all of them describe the same pixel.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int H_FP            = H_FP_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BP            = H_BP_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int V_FP            = V_FP_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BP            = V_BP_DEF,
    parameter int CLK_DIV         = CLK_DIV_DEF,
    parameter int SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [COORD_W-1:0] hcount,
    output logic [COORD_W-1:0] vcount,
    output logic               blank,
    output logic               hsync,
    output logic               vsync,
    output logic               pix_en,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic               SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    if (CLK_DIV < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic [COORD_W-1:0] hcount_q, hcount_d;
    logic [COORD_W-1:0] vcount_q, vcount_d;
    logic               blank_q, blank_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               tick;

    pix_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_en (
        .clk      (clk),
        .reset    (reset),
        .en_i     (en),
        .tick_o   (tick),
        .pix_en_o (pix_en)
    );

    // Decode is taken from the next-state counters so it lands in the same register stage.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (tick) begin
            if (hcount_q == H_LAST) begin
                hcount_d     = '0;
                line_start_d = 1'b1;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + ONE;
                end
            end else begin
                hcount_d = hcount_q + ONE;
            end
        end
        blank_d = (hcount_d >= H_ACT) || (vcount_d >= V_ACT);
        hsync_d = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? SYNC_ON : ~SYNC_ON;
        vsync_d = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? SYNC_ON : ~SYNC_ON;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            blank_q       <= 1'b0;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            blank_q       <= blank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign blank       = blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance checked via a pixel-indexed scoreboard,
// plus a tiny-raster instance (CLK_DIV=1, active-high sync) for frame-level behaviour.
module tb_vga_timing_gen;

    logic        clk;
    logic        reset, en, reset2, en2;
    logic [10:0] hcount, vcount, hcount2, vcount2;
    logic        blank, hsync, vsync, pix_en, line_start, frame_start;
    logic        blank2, hsync2, vsync2, pix_en2, line_start2, frame_start2;

    int vectors  = 0;
    int failures = 0;
    int pixCount = 0;
    int fsCount  = 0;
    int lsCount  = 0;

    typedef struct {
        int          idx;
        logic [10:0] h;
        logic [10:0] v;
        logic        b;
        logic        hs;
        logic        vs;
        logic        ls;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    vga_timing_gen dut (
        .clk(clk), .reset(reset), .en(en),
        .hcount(hcount), .vcount(vcount), .blank(blank), .hsync(hsync), .vsync(vsync),
        .pix_en(pix_en), .line_start(line_start), .frame_start(frame_start)
    );

    // 16x10 raster: hsync on h 10..12, vsync on v 7..8, 160 clks per frame
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .SYNC_ACTIVE_LOW(0)
    ) dut2 (
        .clk(clk), .reset(reset2), .en(en2),
        .hcount(hcount2), .vcount(vcount2), .blank(blank2), .hsync(hsync2), .vsync(vsync2),
        .pix_en(pix_en2), .line_start(line_start2), .frame_start(frame_start2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e_in);
        reset = r;
        en    = e_in;
    endtask

    task automatic pushExp(input int idx, input int h, input int v, input logic b,
                           input logic hs, input logic vs, input logic ls);
        exp_t x;
        x.idx = idx; x.h = 11'(h); x.v = 11'(v);
        x.b = b; x.hs = hs; x.vs = vs; x.ls = ls;
        sbq.push_back(x);
    endtask

    // Hand-computed positions keyed by pixel number since reset (pixel 1 = first pix_en)
    task automatic loadScoreboard();
        pushExp(1,   1,   0, 0, 1, 1, 0);
        pushExp(2,   2,   0, 0, 1, 1, 0);
        pushExp(123, 123, 0, 0, 1, 1, 0);
        pushExp(124, 124, 0, 0, 1, 1, 0);
        pushExp(639, 639, 0, 0, 1, 1, 0);
        pushExp(640, 640, 0, 1, 1, 1, 0);
        pushExp(655, 655, 0, 1, 1, 1, 0);
        pushExp(656, 656, 0, 1, 0, 1, 0);
        pushExp(751, 751, 0, 1, 0, 1, 0);
        pushExp(752, 752, 0, 1, 1, 1, 0);
        pushExp(799, 799, 0, 1, 1, 1, 0);
        pushExp(800, 0,   1, 0, 1, 1, 1);
        pushExp(801, 1,   1, 0, 1, 1, 0);
    endtask

    // Monitor: every pix_en presents a pixel; compare it when the scoreboard head matches
    always @(negedge clk) begin
        if (reset) begin
            pixCount = 0;
        end else begin
            if (frame_start) fsCount++;
            if (line_start)  lsCount++;
            if (pix_en) begin
                pixCount++;
                if (sbq.size() != 0 && sbq[0].idx == pixCount) begin
                    e = sbq.pop_front();
                    checkOutput($sformatf("px%0d_hcount", e.idx), 32'(hcount), 32'(e.h));
                    checkOutput($sformatf("px%0d_vcount", e.idx), 32'(vcount), 32'(e.v));
                    checkOutput($sformatf("px%0d_blank", e.idx), 32'(blank), 32'(e.b));
                    checkOutput($sformatf("px%0d_hsync", e.idx), 32'(hsync), 32'(e.hs));
                    checkOutput($sformatf("px%0d_vsync", e.idx), 32'(vsync), 32'(e.vs));
                    checkOutput($sformatf("px%0d_line_start", e.idx), 32'(line_start), 32'(e.ls));
                end
            end
        end
    end

    initial begin
        int timedOut;
        int cnt;
        int hsHigh, vsHigh, bHigh, pHigh, lsWin, fsWin;

        applyStimulus(1'b1, 1'b0);
        reset2 = 1'b1;
        en2    = 1'b0;
        loadScoreboard();
        repeat (3) @(negedge clk);

        checkOutput("rst_hcount", 32'(hcount), 0);
        checkOutput("rst_vcount", 32'(vcount), 0);
        checkOutput("rst_blank", 32'(blank), 0);
        checkOutput("rst_hsync", 32'(hsync), 1);
        checkOutput("rst_vsync", 32'(vsync), 1);
        checkOutput("rst_pix_en", 32'(pix_en), 0);
        checkOutput("rst_line_start", 32'(line_start), 0);
        checkOutput("rst_frame_start", 32'(frame_start), 0);
        checkOutput("rst2_hsync", 32'(hsync2), 0);
        checkOutput("rst2_vsync", 32'(vsync2), 0);

        // First pix_en arrives two clocks after release
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("clk1_pix_en", 32'(pix_en), 0);
        checkOutput("clk1_hcount", 32'(hcount), 0);
        @(negedge clk);
        checkOutput("clk2_pix_en", 32'(pix_en), 1);
        checkOutput("clk2_hcount", 32'(hcount), 1);

        timedOut = 1;
        for (int i = 0; i < 1000; i++) begin
            if (hcount == 11'd123) begin timedOut = 0; break; end
            @(negedge clk);
        end
        checkOutput("wait_h123_timeout", 32'(timedOut), 0);

        // Freeze for 37 clocks
        applyStimulus(1'b0, 1'b0);
        cnt = 0;
        repeat (37) begin
            @(negedge clk);
            if (pix_en) cnt++;
        end
        checkOutput("freeze_pix_en_count", 32'(cnt), 0);
        checkOutput("freeze_hcount", 32'(hcount), 123);
        checkOutput("freeze_hsync", 32'(hsync), 1);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("resume1_hcount", 32'(hcount), 123);
        checkOutput("resume1_pix_en", 32'(pix_en), 0);
        @(negedge clk);
        checkOutput("resume2_hcount", 32'(hcount), 124);
        checkOutput("resume2_pix_en", 32'(pix_en), 1);

        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (pix_en) cnt++;
        end
        checkOutput("pix_en_cadence", 32'(cnt), 100);

        timedOut = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (vcount == 11'd1 && hcount == 11'd700) begin timedOut = 0; break; end
        end
        checkOutput("wait_v1h700_timeout", 32'(timedOut), 0);
        checkOutput("line_start_pulses", 32'(lsCount), 1);
        checkOutput("scoreboard_drained", 32'(sbq.size()), 0);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("arst_hcount", 32'(hcount), 0);
        checkOutput("arst_vcount", 32'(vcount), 0);
        checkOutput("arst_blank", 32'(blank), 0);
        checkOutput("arst_hsync", 32'(hsync), 1);
        checkOutput("arst_pix_en", 32'(pix_en), 0);
        checkOutput("arst_line_start", 32'(line_start), 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("no_frame_start_main", 32'(fsCount), 0);

        // Tiny raster, CLK_DIV=1
        reset2 = 1'b0;
        en2    = 1'b1;
        @(negedge clk);
        checkOutput("d2_clk1_pix_en", 32'(pix_en2), 1);
        checkOutput("d2_clk1_hcount", 32'(hcount2), 1);

        timedOut = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_start2) begin timedOut = 0; break; end
        end
        checkOutput("d2_wait_fs_timeout", 32'(timedOut), 0);
        checkOutput("d2_fs_hcount", 32'(hcount2), 0);
        checkOutput("d2_fs_vcount", 32'(vcount2), 0);
        checkOutput("d2_fs_line_start", 32'(line_start2), 1);

        hsHigh = 0; vsHigh = 0; bHigh = 0; pHigh = 0; lsWin = 0; fsWin = 0;
        for (int i = 0; i < 160; i++) begin
            if (hsync2)       hsHigh++;
            if (vsync2)       vsHigh++;
            if (blank2)       bHigh++;
            if (pix_en2)      pHigh++;
            if (line_start2)  lsWin++;
            if (frame_start2) fsWin++;
            @(negedge clk);
        end
        checkOutput("d2_frame_period", 32'(frame_start2), 1);
        checkOutput("d2_fs_per_frame", 32'(fsWin), 1);
        checkOutput("d2_hsync_high", 32'(hsHigh), 30);
        checkOutput("d2_vsync_high", 32'(vsHigh), 32);
        checkOutput("d2_blank_high", 32'(bHigh), 112);
        checkOutput("d2_pix_en_high", 32'(pHigh), 160);
        checkOutput("d2_line_starts", 32'(lsWin), 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
